// File: rtl/hex_word_scanner_if.sv
// Load handshake and digit-drive signals shared between the word source and the scanner.
// The scanner uses the slave modport; whoever supplies words and consumes digits uses master.
interface hex_word_scanner_if #(
  parameter int WIDTH = 32
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             repeat_en;
  logic             hold;
  logic [3:0]       nibble;
  logic             blank;
  logic             dp;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, repeat_en, hold,
    input  load_ready, nibble, blank, dp, busy, done
  );

  modport slave (
    input  load_valid, load_data, repeat_en, hold,
    output load_ready, nibble, blank, dp, busy, done
  );
endinterface

// File: rtl/hex_word_scanner.sv
// Scans a captured word onto one seven-segment digit, MS nibble first, with a dwell
// per digit and an optional blank gap between digits.
module hex_word_scanner #(
  parameter int WIDTH = 32,
  parameter int DWELL = 1000000,
  parameter int GAP   = 250000
) (
  input  logic               clk,
  input  logic               rst,
  hex_word_scanner_if.slave  bus
);

  localparam int NDIG = WIDTH / 4;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int MAXC = (DWELL > GAP) ? ((DWELL > 2) ? DWELL : 2) : ((GAP > 2) ? GAP : 2);
  localparam int CW   = $clog2(MAXC);

  localparam logic [IW-1:0] IDX_TOP   = IW'(NDIG - 1);
  localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_END   = CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] word, word_src;
  logic             cap, adv, done_n, show_n;
  logic [3:0]       nib_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    cap     = 1'b0;
    adv     = 1'b0;
    done_n  = 1'b0;
    if (!bus.hold) begin
      unique case (state)
        S_IDLE: begin
          if (bus.load_valid) begin
            cap     = 1'b1;
            idx_n   = IDX_TOP;
            cnt_n   = '0;
            state_n = S_SHOW;
          end
        end
        S_SHOW: begin
          if (cnt == DWELL_END) begin
            if (GAP > 0) begin
              state_n = S_GAP;
              cnt_n   = '0;
            end else begin
              adv = 1'b1;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (cnt == GAP_END) adv = 1'b1;
          else                cnt_n = cnt + CW'(1);
        end
        default: state_n = S_IDLE;
      endcase
    end

    // Digit advance: next lower nibble, wrap to the top when looping, else finish.
    if (adv) begin
      cnt_n = '0;
      if (idx != '0) begin
        idx_n   = idx - IW'(1);
        state_n = S_SHOW;
      end else if (bus.repeat_en) begin
        idx_n   = IDX_TOP;
        state_n = S_SHOW;
      end else begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    end

    // Outputs are derived from next state so the registered copies line up with it.
    word_src = cap ? bus.load_data : word;
    show_n   = (state_n == S_SHOW);
    nib_n    = show_n ? 4'(word_src >> {idx_n, 2'b00}) : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      idx            <= '0;
      bus.load_ready <= 1'b1;
      bus.blank      <= 1'b1;
      bus.nibble     <= 4'h0;
      bus.dp         <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      idx            <= idx_n;
      bus.load_ready <= (state_n == S_IDLE);
      bus.blank      <= !show_n;
      bus.nibble     <= nib_n;
      bus.dp         <= show_n && (idx_n == IDX_TOP);
      bus.busy       <= (state_n != S_IDLE);
      bus.done       <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) word <= bus.load_data;
  end

endmodule

// File: tb/tb_hex_word_scanner.sv
// Bench for hex_word_scanner: two 8-bit instances (gap of 1 and no gap) checked every
// cycle against a timeline model, plus literal expectations at key cycles.
module tb_hex_word_scanner;

  localparam int DW = 3;
  localparam int ND = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hex_word_scanner_if #(.WIDTH(8)) i0 ();
  hex_word_scanner_if #(.WIDTH(8)) i1 ();

  hex_word_scanner #(.WIDTH(8), .DWELL(DW), .GAP(1)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
  hex_word_scanner #(.WIDTH(8), .DWELL(DW), .GAP(0)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int gapv[2] = '{1, 0};

  // Model: whether a word is active, the word, and elapsed non-held cycles since accept.
  bit         m_act[2];
  logic [7:0] m_word[2];
  int         m_t[2];
  bit         m_done[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic       lv, rep, hd;
      logic [7:0] ld;
      int         p;
      lv  = (d == 0) ? i0.load_valid : i1.load_valid;
      ld  = (d == 0) ? i0.load_data  : i1.load_data;
      rep = (d == 0) ? i0.repeat_en  : i1.repeat_en;
      hd  = (d == 0) ? i0.hold       : i1.hold;
      p   = DW + gapv[d];
      if (rst) begin
        m_act[d]  <= 1'b0;
        m_done[d] <= 1'b0;
      end else if (hd) begin
        m_done[d] <= 1'b0;
      end else begin
        m_done[d] <= 1'b0;
        if (!m_act[d]) begin
          if (lv) begin
            m_act[d]  <= 1'b1;
            m_word[d] <= ld;
            m_t[d]    <= 0;
          end
        end else if (m_t[d] + 1 == ND * p) begin
          if (rep) m_t[d] <= 0;
          else begin
            m_act[d]  <= 1'b0;
            m_done[d] <= 1'b1;
          end
        end else begin
          m_t[d] <= m_t[d] + 1;
        end
      end
    end
  end

  task automatic cmp(input int d, input logic [3:0] nib, input logic bl, input logic dpv,
                     input logic bz, input logic dn, input logic rdy);
    int         k, ph, p;
    logic [3:0] enib;
    logic       ebl, edp;
    string      s;
    s    = (d == 0) ? "u0" : "u1";
    p    = DW + gapv[d];
    enib = 4'h0;
    ebl  = 1'b1;
    edp  = 1'b0;
    if (m_act[d]) begin
      k  = m_t[d] / p;
      ph = m_t[d] % p;
      if (ph < DW) begin
        ebl  = 1'b0;
        enib = 4'(m_word[d] >> (4 * (ND - 1 - k)));
        edp  = (k == 0);
      end
    end
    check({s, ".nibble"},     32'(nib), 32'(enib));
    check({s, ".blank"},      32'(bl),  32'(ebl));
    check({s, ".dp"},         32'(dpv), 32'(edp));
    check({s, ".busy"},       32'(bz),  32'(m_act[d]));
    check({s, ".done"},       32'(dn),  32'(m_done[d]));
    check({s, ".load_ready"}, 32'(rdy), 32'(!m_act[d]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, i0.nibble, i0.blank, i0.dp, i0.busy, i0.done, i0.load_ready);
      cmp(1, i1.nibble, i1.blank, i1.dp, i1.busy, i1.done, i1.load_ready);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int d, input logic lv, input logic [7:0] ld);
    if (d == 0) begin i0.load_valid = lv; i0.load_data = ld; end
    else        begin i1.load_valid = lv; i1.load_data = ld; end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    i0.repeat_en = 1'b0; i0.hold = 1'b0;
    i1.repeat_en = 1'b0; i1.hold = 1'b0;
    tick();
    chk_en = 1'b1;
    ticks(2);
    check("rst.u0.load_ready", 32'(i0.load_ready), 32'd1);
    check("rst.u0.blank",      32'(i0.blank),      32'd1);
    check("rst.u0.nibble",     32'(i0.nibble),     32'd0);
    check("rst.u0.busy",       32'(i0.busy),       32'd0);
    check("rst.u1.done",       32'(i1.done),       32'd0);
    rst = 1'b0;
    tick();

    // 0xA5 with one gap cycle
    drive(0, 1'b1, 8'hA5); tick(); drive(0, 1'b0, 8'h00);
    check("a5.c1.nibble", 32'(i0.nibble), 32'hA);
    check("a5.c1.dp",     32'(i0.dp),     32'd1);
    check("a5.c1.blank",  32'(i0.blank),  32'd0);
    ticks(3);
    check("a5.c4.blank",  32'(i0.blank),  32'd1);
    tick();
    check("a5.c5.nibble", 32'(i0.nibble), 32'h5);
    check("a5.c5.dp",     32'(i0.dp),     32'd0);
    ticks(3);
    check("a5.c8.blank",  32'(i0.blank),  32'd1);
    tick();
    check("a5.c9.done",   32'(i0.done),       32'd1);
    check("a5.c9.ready",  32'(i0.load_ready), 32'd1);
    check("a5.c9.busy",   32'(i0.busy),       32'd0);
    tick();
    check("a5.c10.done",  32'(i0.done),       32'd0);

    // 0x3C without gap
    drive(1, 1'b1, 8'h3C); tick(); drive(1, 1'b0, 8'h00);
    check("3c.c1.nibble", 32'(i1.nibble), 32'h3);
    check("3c.c1.dp",     32'(i1.dp),     32'd1);
    ticks(3);
    check("3c.c4.nibble", 32'(i1.nibble), 32'hC);
    check("3c.c4.blank",  32'(i1.blank),  32'd0);
    ticks(3);
    check("3c.c7.done",   32'(i1.done),   32'd1);
    tick();

    // 0x12 looping, repeat dropped in the second pass
    i0.repeat_en = 1'b1;
    drive(0, 1'b1, 8'h12); tick(); drive(0, 1'b0, 8'h00);
    check("rep.c1.nibble", 32'(i0.nibble), 32'h1);
    ticks(8);
    check("rep.c9.nibble", 32'(i0.nibble), 32'h1);
    check("rep.c9.dp",     32'(i0.dp),     32'd1);
    check("rep.c9.done",   32'(i0.done),   32'd0);
    tick();
    i0.repeat_en = 1'b0;
    ticks(7);
    check("rep.c17.done",  32'(i0.done),   32'd1);
    tick();
    check("rep.c18.busy",  32'(i0.busy),   32'd0);
    ticks(4);

    // hold for 5 edges inside digit A, with a load pulse while held
    drive(0, 1'b1, 8'hA5); tick(); drive(0, 1'b0, 8'h00);
    tick();
    i0.hold = 1'b1;
    tick();
    drive(0, 1'b1, 8'hFF);
    tick();
    drive(0, 1'b0, 8'h00);
    ticks(3);
    i0.hold = 1'b0;
    check("hold.c7.nibble", 32'(i0.nibble), 32'hA);
    tick();
    check("hold.c8.nibble", 32'(i0.nibble), 32'hA);
    check("hold.c8.blank",  32'(i0.blank),  32'd0);
    tick();
    check("hold.c9.blank",  32'(i0.blank),  32'd1);
    tick();
    check("hold.c10.nibble", 32'(i0.nibble), 32'h5);
    ticks(4);
    check("hold.c14.done",  32'(i0.done),   32'd1);
    tick();

    // hold in idle blocks load acceptance
    i0.hold = 1'b1;
    drive(0, 1'b1, 8'h99);
    ticks(2);
    check("holdidle.busy",  32'(i0.busy),       32'd0);
    check("holdidle.ready", 32'(i0.load_ready), 32'd1);
    drive(0, 1'b0, 8'h00);
    i0.hold = 1'b0;
    tick();

    // reset mid-sequence, then a clean restart and a back-to-back load on done
    drive(0, 1'b1, 8'hA5); tick(); drive(0, 1'b0, 8'h00);
    ticks(5);
    rst = 1'b1;
    tick();
    check("rst6.blank",  32'(i0.blank),      32'd1);
    check("rst6.nibble", 32'(i0.nibble),     32'd0);
    check("rst6.busy",   32'(i0.busy),       32'd0);
    check("rst6.done",   32'(i0.done),       32'd0);
    check("rst6.ready",  32'(i0.load_ready), 32'd1);
    rst = 1'b0;
    tick();
    check("rst6.c8.done", 32'(i0.done), 32'd0);
    drive(0, 1'b1, 8'h7E); tick(); drive(0, 1'b0, 8'h00);
    check("7e.c1.nibble", 32'(i0.nibble), 32'h7);
    check("7e.c1.dp",     32'(i0.dp),     32'd1);
    ticks(8);
    check("7e.c9.done",   32'(i0.done),   32'd1);
    drive(0, 1'b1, 8'hF0); tick(); drive(0, 1'b0, 8'h00);
    check("f0.c1.nibble", 32'(i0.nibble), 32'hF);
    check("f0.c1.dp",     32'(i0.dp),     32'd1);
    check("f0.c1.busy",   32'(i0.busy),   32'd1);
    ticks(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_word_scanner.md
# hex_word_scanner

Sequences a captured multi-nibble word onto a single seven-segment digit, one hex nibble at a time, most-significant first. It sits directly upstream of the hex-to-segment decoder: `nibble` drives the decoder's 4-bit value input, while `blank` and `dp` gate the decoded segments and the decimal point at the pad stage. Each digit is held for a programmable dwell time, followed by an optional blank gap so that repeated digits stay distinguishable. The word is loaded through a valid/ready handshake.

## Interface

Parameters:
- `WIDTH`, 32: loaded word width in bits; must be a multiple of 4 and ≥ 4. NDIG = WIDTH/4.
- `DWELL`, 1000000: cycles each digit is shown; must be ≥ 1.
- `GAP`, 250000: blank cycles after each digit; 0 allowed, meaning no gap.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `load_valid`, in, 1: `load_data` is valid.
- `load_data`, in, WIDTH: word to display.
- `load_ready`, out, 1: block can accept a word; high only in IDLE.
- `repeat_en`, in, 1: when high, the word loops continuously instead of finishing.
- `hold`, in, 1: freezes the sequence; all state, counters and outputs hold.
- `nibble`, out, 4: current hex digit, to the decoder.
- `blank`, out, 1: when high, all segments must be off.
- `dp`, out, 1: decimal point; marks the first (most-significant) digit.
- `busy`, out, 1: high in SHOW or GAP.
- `done`, out, 1: one-cycle pulse when a non-repeating sequence completes.

One clock; reset is synchronous and active-high.

## Operation

- States:
  - IDLE: `load_ready`=1, `blank`=1, `nibble`=0, `dp`=0, `busy`=0.
  - SHOW: `blank`=0, `nibble`=current digit, `dp`=1 only when idx=NDIG-1, `busy`=1.
  - GAP: `blank`=1, `nibble`=0, `dp`=0, `busy`=1.
- IDLE→SHOW on `load_valid`&&`load_ready` at a clock edge. That edge captures `load_data` into a word register, sets idx=NDIG-1 and clears the counter.
- SHOW: the counter counts 0..DWELL-1.
  - At DWELL-1: if GAP>0, go to GAP with the counter cleared; if GAP=0, perform the digit-advance step directly.
- GAP: the counter counts 0..GAP-1. At GAP-1, perform the digit-advance step.
- Digit-advance step:
  - If idx>0: idx←idx-1, go to SHOW.
  - If idx=0 and `repeat_en`=1 (sampled at that edge): idx←NDIG-1, go to SHOW, keeping the same captured word.
  - If idx=0 and `repeat_en`=0: go to IDLE and assert `done` for exactly the next cycle.
- Digit value is word[4*idx+3 : 4*idx]. The captured word never changes while busy; `load_data` is ignored outside the handshake.
- `hold`=1 blocks every transition, counter increment and load acceptance. `load_ready` stays at its state value, but no capture occurs while `hold` is high. `done` is not extended by `hold`; it is a single pulse.
- Clearing `repeat_en` mid-loop takes effect at the next idx=0 advance; the current pass finishes.
- Counter width is $clog2(max(DWELL,GAP,2)). Counters never wrap past their terminal value.

## Timing

- All outputs are registered. Reset values: `load_ready`=1, `blank`=1, `nibble`=0, `dp`=0, `busy`=0, `done`=0, state IDLE.
- Reset asserted mid-sequence returns to IDLE on the next edge, discards the word, and produces no `done`.
- With the accept edge E0, the first digit is visible cycles 1..DWELL after E0, with `dp`=1.
- A non-repeating sequence is busy for NDIG*(DWELL+GAP) cycles. `done` and `load_ready` are both high in the following cycle.
- A load presented in the `done` cycle is accepted at that cycle's closing edge, giving zero idle-cycle back-to-back sequences.

## Test plan

- WIDTH=8, DWELL=3, GAP=1. Load 0xA5 → cycles 1–3: nibble=A, dp=1, blank=0; cycle 4: blank=1; cycles 5–7: nibble=5, dp=0; cycle 8: blank=1; cycle 9: done=1, load_ready=1, busy=0. `done` is low on every other cycle.
- Same parameters with GAP=0. Load 0x3C → cycles 1–3: nibble=3, dp=1; cycles 4–6: nibble=C, dp=0; cycle 7: done=1. `blank` is never high during cycles 1–6.
- `repeat_en`=1, load 0x12 → the 1,gap,2,gap pattern repeats. Drop `repeat_en` during the second pass → exactly one `done` after that pass ends; no further digits.
- Assert `hold` for 5 cycles in the middle of digit A → nibble=A stays 5 extra cycles, then 2 more A cycles follow. `load_valid` pulsed during the hold causes no capture.
- Assert `rst` on cycle 6 of the 0xA5 run → the next cycle shows IDLE reset values with done=0. A new load of 0x7E then starts cleanly with nibble=7, dp=1.
- With `done` high, present `load_valid` with 0xF0 → it is accepted that edge; the next cycle shows nibble=F, dp=1, busy=1.
